// File: rtl/mips_hazard_ctrl_if.sv
// rtl/mips_hazard_ctrl_if.sv - D-stage hazard control signal bundle (decoder side = master)
interface mips_hazard_ctrl_if #(
    parameter int STAGES = 3
);
    logic [31:0]         instr_D;
    logic                valid_D;
    logic                flush;
    logic                stall;
    logic [2:0]          fwd_rs;
    logic [2:0]          fwd_rt;
    logic                md_busy;
    logic [5*STAGES-1:0] wa_bus;
    logic [STAGES-1:0]   we_bus;

    modport master (
        output instr_D, valid_D, flush,
        input  stall, fwd_rs, fwd_rt, md_busy, wa_bus, we_bus
    );

    modport slave (
        input  instr_D, valid_D, flush,
        output stall, fwd_rs, fwd_rt, md_busy, wa_bus, we_bus
    );
endinterface

// File: rtl/mips_hazard_ctrl.sv
// rtl/mips_hazard_ctrl.sv - depth-generic Tuse/Tnew hazard unit; MD busy interlock under HAZARD_MD_INTERLOCK_EN
module mips_hazard_ctrl #(
    parameter int STAGES   = 3,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic               clk,
    input logic               reset,
    mips_hazard_ctrl_if.slave hz
);
    localparam int CNT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign opcode = hz.instr_D[31:26];
    assign rs     = hz.instr_D[25:21];
    assign rt     = hz.instr_D[20:16];
    assign rd     = hz.instr_D[15:11];
    assign funct  = hz.instr_D[5:0];

    logic [1:0] dec_tuse_rs;
    logic [1:0] dec_tuse_rt;
    logic       dec_we;
    logic [4:0] dec_wa;
    logic [1:0] dec_tnew;
    logic       dec_md_class;
    logic [1:0] dec_md_start;

    // tuse of 3 means the operand is never read
    always_comb begin
        dec_tuse_rs  = 2'd3;
        dec_tuse_rt  = 2'd3;
        dec_we       = 1'b0;
        dec_wa       = 5'd0;
        dec_tnew     = 2'd0;
        dec_md_class = 1'b0;
        dec_md_start = 2'b00;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03: begin
                        dec_tuse_rt = 2'd1;
                        dec_we      = 1'b1;
                        dec_wa      = rd;
                        dec_tnew    = 2'd1;
                    end
                    6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2a, 6'h2b: begin
                        dec_tuse_rs = 2'd1;
                        dec_tuse_rt = 2'd1;
                        dec_we      = 1'b1;
                        dec_wa      = rd;
                        dec_tnew    = 2'd1;
                    end
                    6'h08: dec_tuse_rs = 2'd0;
                    6'h09: begin
                        dec_tuse_rs = 2'd0;
                        dec_we      = 1'b1;
                        dec_wa      = rd;
                        dec_tnew    = 2'd0;
                    end
                    6'h10, 6'h12: begin
                        dec_we       = 1'b1;
                        dec_wa       = rd;
                        dec_tnew     = 2'd1;
                        dec_md_class = 1'b1;
                    end
                    6'h11, 6'h13: begin
                        dec_tuse_rs  = 2'd1;
                        dec_md_class = 1'b1;
                    end
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        dec_tuse_rs  = 2'd1;
                        dec_tuse_rt  = 2'd1;
                        dec_md_class = 1'b1;
                        dec_md_start = funct[1] ? 2'b10 : 2'b01;
                    end
                    default: ;
                endcase
            end
            6'h01: begin
                if (rt[4:1] == 4'd0) dec_tuse_rs = 2'd0;
            end
            6'h03: begin
                dec_we   = 1'b1;
                dec_wa   = 5'd31;
                dec_tnew = 2'd0;
            end
            6'h04, 6'h05: begin
                dec_tuse_rs = 2'd0;
                dec_tuse_rt = 2'd0;
            end
            6'h06, 6'h07: dec_tuse_rs = 2'd0;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin
                dec_tuse_rs = 2'd1;
                dec_we      = 1'b1;
                dec_wa      = rt;
                dec_tnew    = 2'd1;
            end
            6'h0f: begin
                dec_we   = 1'b1;
                dec_wa   = rt;
                dec_tnew = 2'd1;
            end
            6'h10: begin
                if (hz.instr_D == 32'h4200_0018) begin
                    dec_we = 1'b0;
                end else if (rs == 5'd0) begin
                    dec_we   = 1'b1;
                    dec_wa   = rt;
                    dec_tnew = 2'd2;
                end else if (rs == 5'd4) begin
                    dec_tuse_rt = 2'd2;
                end
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                dec_tuse_rs = 2'd1;
                dec_we      = 1'b1;
                dec_wa      = rt;
                dec_tnew    = 2'd2;
            end
            6'h28, 6'h29, 6'h2b: begin
                dec_tuse_rs = 2'd1;
                dec_tuse_rt = 2'd2;
            end
            default: ;
        endcase
    end

    logic [STAGES-1:0]      we_d,   we_q;
    logic [STAGES-1:0][4:0] wa_d,   wa_q;
    logic [STAGES-1:0][1:0] tnew_d, tnew_q;

    logic       data_stall;
    logic       md_stall;
    logic       md_busy;
    logic       stall;
    logic       bubble;
    logic       seen_rs;
    logic       seen_rt;
    logic [2:0] fwd_rs;
    logic [2:0] fwd_rt;

    // Only the nearest writer of a register decides the stall; fwd picks the nearest ready one
    always_comb begin
        data_stall = 1'b0;
        seen_rs    = 1'b0;
        seen_rt    = 1'b0;
        fwd_rs     = 3'd0;
        fwd_rt     = 3'd0;
        for (int k = 0; k < STAGES; k++) begin
            if (we_q[k] && (wa_q[k] == rs) && (rs != 5'd0)) begin
                if (!seen_rs && (dec_tuse_rs != 2'd3) && (tnew_q[k] > dec_tuse_rs)) data_stall = 1'b1;
                if ((fwd_rs == 3'd0) && (tnew_q[k] == 2'd0)) fwd_rs = 3'(k + 1);
                seen_rs = 1'b1;
            end
            if (we_q[k] && (wa_q[k] == rt) && (rt != 5'd0)) begin
                if (!seen_rt && (dec_tuse_rt != 2'd3) && (tnew_q[k] > dec_tuse_rt)) data_stall = 1'b1;
                if ((fwd_rt == 3'd0) && (tnew_q[k] == 2'd0)) fwd_rt = 3'(k + 1);
                seen_rt = 1'b1;
            end
        end
    end

    assign stall  = data_stall | md_stall;
    assign bubble = stall | hz.flush | ~hz.valid_D;

    always_comb begin
        we_d      = '0;
        wa_d      = '0;
        tnew_d    = '0;
        we_d[0]   = bubble ? 1'b0 : dec_we;
        wa_d[0]   = bubble ? 5'd0 : dec_wa;
        tnew_d[0] = bubble ? 2'd0 : dec_tnew;
        for (int k = 1; k < STAGES; k++) begin
            we_d[k]   = we_q[k-1];
            wa_d[k]   = wa_q[k-1];
            tnew_d[k] = (tnew_q[k-1] != 2'd0) ? (tnew_q[k-1] - 2'd1) : 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q   <= '0;
            wa_q   <= '0;
            tnew_q <= '0;
        end else begin
            we_q   <= we_d;
            wa_q   <= wa_d;
            tnew_q <= tnew_d;
        end
    end

`ifdef HAZARD_MD_INTERLOCK_EN
    logic [1:0]       s1_md_d, s1_md_q;
    logic [CNT_W-1:0] md_cnt_d, md_cnt_q;

    // The counter loads as the start leaves stage 1, so stage-1 occupancy covers the first busy cycle
    always_comb begin
        s1_md_d = bubble ? 2'b00 : dec_md_start;
        if (s1_md_q == 2'b01) begin
            md_cnt_d = CNT_W'(MULT_LAT);
        end else if (s1_md_q == 2'b10) begin
            md_cnt_d = CNT_W'(DIV_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end else begin
            md_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_md_q  <= 2'b00;
            md_cnt_q <= '0;
        end else begin
            s1_md_q  <= s1_md_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy  = (md_cnt_q != '0) || (s1_md_q != 2'b00);
    assign md_stall = dec_md_class & md_busy;
`else
    logic unused_md;
    assign unused_md = ^{dec_md_class, dec_md_start, (CNT_W != 0)};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

    assign hz.stall   = stall;
    assign hz.fwd_rs  = fwd_rs;
    assign hz.fwd_rt  = fwd_rt;
    assign hz.md_busy = md_busy;
    assign hz.wa_bus  = wa_q;
    assign hz.we_bus  = we_q;
endmodule
